// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: client req/gnt/done handshake plus the shared regfile port bundle
interface regfile_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req, we, gnt, done;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata, rf_i_data, rf_o_data;
  logic [ADDR_WIDTH-1:0] rf_address;
  logic busy, rf_mode;
  modport master (
    output req, we, addr, wdata, rf_o_data,
    input gnt, done, rdata, busy, rf_address, rf_i_data, rf_mode
  );
  modport slave (
    input req, we, addr, wdata, rf_o_data,
    output gnt, done, rdata, busy, rf_address, rf_i_data, rf_mode
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of one regfile, three-cycle setup/access sequence per grant
module regfile_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REQ = 4
) (
  input logic clk,
  input logic rst_n,
  regfile_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, w_q, w_d, win, idx;
  logic we_q, we_d, rf_mode_q, rf_mode_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rf_i_data_q, rf_i_data_d;
  logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      win = bus.req[idx] ? idx : win;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    w_d = w_q;
    we_d = we_q;
    gnt_d = '0;
    done_d = '0;
    rdata_d = rdata_q;
    rf_address_d = rf_address_q;
    rf_i_data_d = rf_i_data_q;
    rf_mode_d = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        w_d = win;
        we_d = bus.we[win];
        rf_address_d = addr_a[win];
        rf_i_data_d = wdata_a[win];
        gnt_d = NUM_REQ'(1) << win;
        ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        state_d = SETUP;
      end
      SETUP: begin
        rf_mode_d = we_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        done_d = NUM_REQ'(1) << w_q;
        rdata_d = we_q ? rdata_q : bus.rf_o_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      w_q <= '0;
      we_q <= 1'b0;
      gnt_q <= '0;
      done_q <= '0;
      rdata_q <= '0;
      rf_address_q <= '0;
      rf_i_data_q <= '0;
      rf_mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      w_q <= w_d;
      we_q <= we_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
      rf_address_q <= rf_address_d;
      rf_i_data_q <= rf_i_data_d;
      rf_mode_q <= rf_mode_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.rdata = rdata_q;
  assign bus.rf_address = rf_address_q;
  assign bus.rf_i_data = rf_i_data_q;
  assign bus.rf_mode = rf_mode_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed and random accesses checked against a transaction-level model
module tb_regfile_arbiter;
  localparam int DW = 16, AW = 4, NR = 4;
  logic clk = 1'b0, rst_n = 1'b0, rf_clr = 1'b1;
  int n_chk = 0, n_pass = 0;
  regfile_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();
  regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [DW-1:0] rf_mem [2**AW];
  logic [AW-1:0] rf_a;
  logic [DW-1:0] rf_d;
  always @(posedge clk) begin
    rf_a <= bus.rf_address;
    rf_d <= bus.rf_i_data;
    if (rf_clr) for (int i = 0; i < 2**AW; i++) rf_mem[i] <= '0;
    else if (bus.rf_mode) rf_mem[rf_a] <= rf_d;
  end
  assign bus.rf_o_data = rf_mem[rf_a];
  logic [DW-1:0] m_mem [2**AW];
  logic [DW-1:0] m_rdata;
  int m_ptr;
  logic [NR-1:0] pend, p_we;
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_wd [NR];
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i] = pend[i];
      bus.we[i] = p_we[i];
      bus.addr[i*AW +: AW] = p_addr[i];
      bus.wdata[i*DW +: DW] = p_wd[i];
    end
  endtask
  task automatic set_req(int i, logic w, int a, int d);
    pend[i] = 1'b1;
    p_we[i] = w;
    p_addr[i] = AW'(a);
    p_wd[i] = DW'(d);
  endtask
  function automatic int rr_pick(logic [NR-1:0] m, int p);
    logic [NR-1:0] s;
    for (int i = 0; i < NR; i++) begin
      s = m >> ((p + i) % NR);
      if (s[0]) return (p + i) % NR;
    end
    return 0;
  endfunction
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
  endtask
  task automatic serve(int n, logic [NR-1:0] keep);
    int w;
    logic tw;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    logic [NR-1:0] keep_w;
    for (int k = 0; k < n; k++) begin
      w = rr_pick(pend, m_ptr);
      tw = p_we[w];
      ta = p_addr[w];
      td = p_wd[w];
      drive();
      tick();
      chk("gnt", {28'd0, bus.gnt}, 32'(1 << w));
      chk("done_setup", {28'd0, bus.done}, 0);
      chk("busy_setup", {31'd0, bus.busy}, 1);
      chk("mode_setup", {31'd0, bus.rf_mode}, 0);
      chk("rf_address", {28'd0, bus.rf_address}, {28'd0, ta});
      chk("rf_i_data", {16'd0, bus.rf_i_data}, {16'd0, td});
      m_ptr = (w + 1) % NR;
      keep_w = keep >> w;
      if (!keep_w[0]) pend = pend & ~(NR'(1) << w);
      drive();
      tick();
      chk("gnt_access", {28'd0, bus.gnt}, 0);
      chk("mode_access", {31'd0, bus.rf_mode}, {31'd0, tw});
      chk("busy_access", {31'd0, bus.busy}, 1);
      chk("addr_hold", {28'd0, bus.rf_address}, {28'd0, ta});
      if (tw) m_mem[ta] = td;
      else m_rdata = m_mem[ta];
      tick();
      chk("done", {28'd0, bus.done}, 32'(1 << w));
      chk("mode_idle", {31'd0, bus.rf_mode}, 0);
      chk("busy_idle", {31'd0, bus.busy}, 0);
      chk("rdata", {16'd0, bus.rdata}, {16'd0, m_rdata});
    end
  endtask
  initial begin
    logic [NR-1:0] mask;
    pend = '0;
    p_we = '0;
    for (int i = 0; i < NR; i++) begin
      p_addr[i] = '0;
      p_wd[i] = '0;
    end
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    m_ptr = 0;
    m_rdata = '0;
    drive();
    repeat (3) tick();
    chk("rst_gnt", {28'd0, bus.gnt}, 0);
    chk("rst_done", {28'd0, bus.done}, 0);
    chk("rst_rdata", {16'd0, bus.rdata}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_mode", {31'd0, bus.rf_mode}, 0);
    chk("rst_addr", {28'd0, bus.rf_address}, 0);
    rst_n = 1'b1;
    rf_clr = 1'b0;
    repeat (2) tick();
    chk("idle_gnt", {28'd0, bus.gnt}, 0);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    set_req(0, 1'b1, 3, 16'hBEEF);
    serve(1, '0);
    set_req(1, 1'b0, 3, 0);
    serve(1, '0);
    chk("read_beef", {16'd0, bus.rdata}, 32'hBEEF);
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 65535));
    serve(4, '0);
    set_req(2, 1'b0, 1, 0);
    serve(1, '0);
    set_req(0, 1'b1, 9, 16'h0909);
    set_req(2, 1'b1, 10, 16'h0A0A);
    serve(2, '0);
    set_req(1, 1'b0, 9, 0);
    serve(3, 4'b0010);
    pend = '0;
    drive();
    do_reset();
    set_req(0, 1'b1, 5, 16'h1234);
    set_req(3, 1'b1, 6, 16'h5678);
    serve(2, '0);
    chk("rdata_after_writes", {16'd0, bus.rdata}, 0);
    set_req(1, 1'b0, 5, 0);
    serve(1, '0);
    chk("read5", {16'd0, bus.rdata}, 32'h1234);
    set_req(2, 1'b0, 6, 0);
    serve(1, '0);
    chk("read6", {16'd0, bus.rdata}, 32'h5678);
    set_req(2, 1'b1, 7, 16'h1111);
    serve(1, '0);
    set_req(0, 1'b1, 7, 16'hAAAA);
    drive();
    tick();
    pend = '0;
    drive();
    tick();
    chk("mode_before_rst", {31'd0, bus.rf_mode}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mode", {31'd0, bus.rf_mode}, 0);
    chk("async_gnt", {28'd0, bus.gnt}, 0);
    chk("async_done", {28'd0, bus.done}, 0);
    chk("async_rdata", {16'd0, bus.rdata}, 0);
    chk("async_busy", {31'd0, bus.busy}, 0);
    tick();
    chk("no_done_after_rst", {28'd0, bus.done}, 0);
    rst_n = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
    set_req(3, 1'b0, 7, 0);
    serve(1, '0);
    chk("read7_prior", {16'd0, bus.rdata}, 32'h1111);
    for (int r = 0; r < 40; r++) begin
      mask = NR'($urandom_range(0, 2**NR - 1));
      for (int i = 0; i < NR; i++)
        if (mask[i]) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 65535));
      if (mask == '0) begin
        drive();
        tick();
        chk("rand_idle_gnt", {28'd0, bus.gnt}, 0);
        chk("rand_idle_busy", {31'd0, bus.busy}, 0);
      end else serve($countones(mask), '0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
